// File: rtl/stream2fifoio.sv
// SRIO IO receive stream to FIFO writer with dstid filter and 2-entry skid.
// Optional STREAM2FIFOIO_LEN_CHECK_EN truncates packets at MAX_BEATS beats.
module stream2fifoio #(
  parameter int MAX_BEATS = 16,
  parameter bit PROMISC   = 1'b0
) (
  input  logic          log_clk,
  input  logic          rst_n,
  input  logic [15:0]   my_id,
  input  logic          rxio_tvalid,
  output logic          rxio_tready,
  input  logic [127:0]  rxio_tdata,
  input  logic [7:0]    rxio_tkeep,
  input  logic          rxio_tlast,
  input  logic [31:0]   rxio_tuser,
  output logic          stream2fifoio_wren,
  output logic [128:0]  stream2fifoio_in,
  input  logic          stream2fifoio_full,
  output logic [15:0]   rx_sorid,
  output logic [15:0]   pkt_cnt,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   keep_err_cnt,
  output logic [15:0]   len_err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [128:0]  ent0_q, ent1_q;
  logic          rd_q, wr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          rdy_q;
  logic [15:0]   sorid_q;
  logic [15:0]   pkt_q, drop_q, kerr_q, lerr_q;

  logic          acc, hit, hdr;
  logic          push, pop, trunc, last_in;

  assign acc  = rxio_tvalid && rdy_q;
  assign hdr  = acc && (state_q == IDLE);
  assign hit  = PROMISC || (rxio_tuser[15:0] == my_id);
  assign pop  = (cnt_q != 2'd0) && !stream2fifoio_full;

`ifdef STREAM2FIFOIO_LEN_CHECK_EN
  logic [15:0] beat_q, beat_n;

  assign beat_n = (state_q == IDLE) ? 16'd1 : beat_q + 16'd1;
  assign trunc  = push && !rxio_tlast &&
                  (beat_n == 16'(MAX_BEATS));

  always_ff @(posedge log_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      lerr_q <= '0;
    end else begin
      if (push) beat_q <= beat_n;
      if (trunc) lerr_q <= lerr_q + 16'd1;
    end
  end
`else
  localparam int unused_max_beats = MAX_BEATS;
  assign trunc  = 1'b0;
  assign lerr_q = '0;
`endif

  assign last_in = rxio_tlast || trunc;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    if (acc) begin
      unique case (1'b1)
        (state_q == IDLE): begin
          push    = hit;
          state_d = hit ? PASS : DROP;
        end
        (state_q == PASS): push = 1'b1;
        default: ;
      endcase
      if (trunc) state_d = DROP;
      if (rxio_tlast) state_d = IDLE;
    end
  end

  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge log_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ent0_q  <= '0;
      ent1_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      sorid_q <= '0;
      pkt_q   <= '0;
      drop_q  <= '0;
      kerr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // ready is a pure register so the upstream sees no comb path
      rdy_q   <= (cnt_d != 2'd2);
      if (push) begin
        if (wr_q) ent1_q <= {last_in, rxio_tdata};
        else      ent0_q <= {last_in, rxio_tdata};
        wr_q <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      if (hdr && hit) begin
        sorid_q <= rxio_tuser[31:16];
        pkt_q   <= pkt_q + 16'd1;
      end
      if (hdr && !hit) drop_q <= drop_q + 16'd1;
      if (push && rxio_tkeep != 8'hff)
        kerr_q <= kerr_q + 16'd1;
    end
  end

  assign rxio_tready        = rdy_q;
  assign stream2fifoio_wren = pop;
  assign stream2fifoio_in   = rd_q ? ent1_q : ent0_q;
  assign rx_sorid           = sorid_q;
  assign pkt_cnt            = pkt_q;
  assign drop_cnt           = drop_q;
  assign keep_err_cnt       = kerr_q;
  assign len_err_cnt        = lerr_q;

endmodule

// File: tb/tb_stream2fifoio.sv
// Directed bench for stream2fifoio: vector table plus
// backpressure, promiscuous, length and reset sequences.
module tb_stream2fifoio;

  logic          log_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic [15:0]   my_id;
  logic          rxio_tvalid;
  logic [127:0]  rxio_tdata;
  logic [7:0]    rxio_tkeep;
  logic          rxio_tlast;
  logic [31:0]   rxio_tuser;
  logic          full;

  logic          rdy, wren;
  logic [128:0]  din;
  logic [15:0]   sorid, pkt, drop, kerr, lerr;

  logic          p_rdy, p_wren;
  logic [128:0]  p_din;
  logic [15:0]   p_sorid, p_pkt, p_drop, p_kerr, p_lerr;

  always #5 log_clk = ~log_clk;

  stream2fifoio #(.MAX_BEATS(4), .PROMISC(1'b0)) u_dut (
    .log_clk(log_clk), .rst_n(rst_n), .my_id(my_id),
    .rxio_tvalid(rxio_tvalid), .rxio_tready(rdy),
    .rxio_tdata(rxio_tdata), .rxio_tkeep(rxio_tkeep),
    .rxio_tlast(rxio_tlast), .rxio_tuser(rxio_tuser),
    .stream2fifoio_wren(wren), .stream2fifoio_in(din),
    .stream2fifoio_full(full), .rx_sorid(sorid),
    .pkt_cnt(pkt), .drop_cnt(drop),
    .keep_err_cnt(kerr), .len_err_cnt(lerr)
  );

  stream2fifoio #(.MAX_BEATS(16), .PROMISC(1'b1)) u_prm (
    .log_clk(log_clk), .rst_n(rst_n), .my_id(my_id),
    .rxio_tvalid(rxio_tvalid), .rxio_tready(p_rdy),
    .rxio_tdata(rxio_tdata), .rxio_tkeep(rxio_tkeep),
    .rxio_tlast(rxio_tlast), .rxio_tuser(rxio_tuser),
    .stream2fifoio_wren(p_wren), .stream2fifoio_in(p_din),
    .stream2fifoio_full(full), .rx_sorid(p_sorid),
    .pkt_cnt(p_pkt), .drop_cnt(p_drop),
    .keep_err_cnt(p_kerr), .len_err_cnt(p_lerr)
  );

  typedef struct {
    logic         v;
    logic         l;
    logic [7:0]   k;
    logic [31:0]  u;
    logic [127:0] d;
    logic         er;
    logic         ew;
    logic         el;
    logic [127:0] ed;
  } vec_t;

  vec_t tv[$];
  int checks = 0;
  int errors = 0;

  logic          mon_en = 1'b0;
  logic [128:0]  got[$];

  always @(posedge log_clk)
    if (mon_en && wren) got.push_back(din);

  task automatic chk(input string nm,
                     input logic [128:0] act,
                     input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic l,
                              input logic [7:0] k,
                              input logic [31:0] u,
                              input logic [127:0] d,
                              input logic er, input logic ew,
                              input logic el,
                              input logic [127:0] ed);
    vec_t r;
    r.v = v; r.l = l; r.k = k; r.u = u; r.d = d;
    r.er = er; r.ew = ew; r.el = el; r.ed = ed;
    tv.push_back(r);
  endfunction

  task automatic idle_in();
    rxio_tvalid = 1'b0;
    rxio_tlast  = 1'b0;
    rxio_tkeep  = 8'hff;
    rxio_tuser  = '0;
    rxio_tdata  = '0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rxio_tvalid = tv[i].v;
      rxio_tlast  = tv[i].l;
      rxio_tkeep  = tv[i].k;
      rxio_tuser  = tv[i].u;
      rxio_tdata  = tv[i].d;
      full        = 1'b0;
      #1;
      chk($sformatf("row%0d_ready", i), rdy, tv[i].er);
      chk($sformatf("row%0d_wren", i), wren, tv[i].ew);
      if (tv[i].ew)
        chk($sformatf("row%0d_in", i), din,
            {tv[i].el, tv[i].ed});
      @(posedge log_clk); #1;
    end
  endtask

  int beat, cyc, rdy_low;

  initial begin
    my_id = 16'h0012;
    full  = 1'b0;
    idle_in();

    // pkt1: 4 beats, match
    add(1,0,8'hff,32'h00340012,128'h1, 1,0,0,128'h0);
    add(1,0,8'hff,32'h0,       128'h2, 1,1,0,128'h1);
    add(1,0,8'hff,32'h0,       128'h3, 1,1,0,128'h2);
    add(1,1,8'hff,32'h0,       128'h4, 1,1,0,128'h3);
    add(0,0,8'hff,32'h0,       128'h0, 1,1,1,128'h4);
    add(0,0,8'hff,32'h0,       128'h0, 1,0,0,128'h0);
    // 1-beat, partial keep
    add(1,1,8'h0f,32'h00780012,128'h77,1,0,0,128'h0);
    add(0,0,8'hff,32'h0,       128'h0, 1,1,1,128'h77);
    // 3-beat mismatch, then 1-beat match
    add(1,0,8'hff,32'h00350099,128'h11,1,0,0,128'h0);
    add(1,0,8'hff,32'h0,       128'h12,1,0,0,128'h0);
    add(1,1,8'hff,32'h0,       128'h13,1,0,0,128'h0);
    add(1,1,8'hff,32'h00560012,128'ha, 1,0,0,128'h0);
    add(0,0,8'hff,32'h0,       128'h0, 1,1,1,128'ha);
    add(0,0,8'hff,32'h0,       128'h0, 1,0,0,128'h0);
`ifdef STREAM2FIFOIO_LEN_CHECK_EN
    // 6-beat packet cut at 4, then a normal 1-beat packet
    add(1,0,8'hff,32'h00340012,128'h301,1,0,0,128'h0);
    add(1,0,8'hff,32'h0,       128'h302,1,1,0,128'h301);
    add(1,0,8'hff,32'h0,       128'h303,1,1,0,128'h302);
    add(1,0,8'hff,32'h0,       128'h304,1,1,0,128'h303);
    add(1,0,8'hff,32'h0,       128'h305,1,1,1,128'h304);
    add(1,1,8'hff,32'h0,       128'h306,1,0,0,128'h0);
    add(1,1,8'hff,32'h00340012,128'h307,1,0,0,128'h0);
    add(0,0,8'hff,32'h0,       128'h0,  1,1,1,128'h307);
    add(0,0,8'hff,32'h0,       128'h0,  1,0,0,128'h0);
`endif

    // reset state
    #12;
    chk("rst_ready", rdy, 1'b0);
    chk("rst_wren", wren, 1'b0);
    chk("rst_in", din, 129'h0);
    chk("rst_cnts", {sorid, pkt, drop, kerr, lerr}, 129'h0);
    @(negedge log_clk); rst_n = 1'b1;
    @(posedge log_clk); #1;
    chk("ready_after_rst", rdy, 1'b1);

    run_rows(0, 6);
    chk("pkt_cnt_1", pkt, 16'd1);
    chk("sorid_1", sorid, 16'h0034);
    run_rows(6, 8);
    chk("keep_err", kerr, 16'd1);
    chk("sorid_2", sorid, 16'h0078);
    run_rows(8, 14);
    chk("drop_cnt", drop, 16'd1);
    chk("pkt_cnt_3", pkt, 16'd3);
    chk("sorid_3", sorid, 16'h0056);
    chk("prm_drop", p_drop, 16'd0);
    chk("prm_pkt", p_pkt, 16'd4);
    chk("prm_keep", p_kerr, 16'd1);
    chk("prm_sorid", p_sorid, 16'h0056);

    // backpressure: full held 10 cycles mid-packet
    got.delete();
    mon_en  = 1'b1;
    beat    = 0;
    cyc     = 0;
    rdy_low = 0;
    while (beat < 8 && cyc < 100) begin
      rxio_tvalid = 1'b1;
      rxio_tkeep  = 8'hff;
      rxio_tuser  = (beat == 0) ? 32'h00340012 : 32'h0;
      rxio_tdata  = 128'h100 + 128'(beat);
      rxio_tlast  = (beat == 7);
      full        = (cyc >= 2 && cyc < 12);
      if (cyc == 12) chk("bp_accepted", beat, 3);
      if (cyc >= 3 && cyc < 12 && !rdy) rdy_low++;
      #1;
      @(posedge log_clk);
      if (rdy) beat++;
      #1;
      cyc++;
    end
    if (beat < 8)
      chk("bp_timeout", beat, 8);
    idle_in();
    full = 1'b0;
    repeat (4) @(posedge log_clk);
    #1;
    mon_en = 1'b0;
    chk("bp_ready_low", rdy_low, 9);
    chk("bp_writes", got.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got.size())
        chk($sformatf("bp_beat%0d", i), got[i],
            {(i == 7), 128'h100 + 128'(i)});
    chk("bp_pkt", pkt, 16'd4);
    chk("bp_ready_end", rdy, 1'b1);

`ifdef STREAM2FIFOIO_LEN_CHECK_EN
    run_rows(14, 23);
    chk("len_err", lerr, 16'd1);
    chk("len_pkt", pkt, 16'd6);
`else
    chk("len_err_tied", lerr, 16'd0);
`endif

    // reset during beat 2 of a passed packet
    rxio_tvalid = 1'b1;
    rxio_tlast  = 1'b0;
    rxio_tuser  = 32'h00340012;
    rxio_tdata  = 128'h201;
    @(posedge log_clk); #1;
    rxio_tuser  = 32'h0;
    rxio_tdata  = 128'h202;
    #1;
    chk("mid_wren", wren, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wren", wren, 1'b0);
    chk("mid_rst_cnts", {sorid, pkt, drop, kerr}, 129'h0);
    chk("mid_rst_ready", rdy, 1'b0);
    rxio_tuser = 32'h00340099;
    rxio_tdata = 128'h203;
    @(negedge log_clk);
    @(negedge log_clk); rst_n = 1'b1;
    @(posedge log_clk); #1;
    chk("post_rst_ready", rdy, 1'b1);
    chk("post_rst_drop0", drop, 16'd0);
    @(posedge log_clk); #1;
    chk("post_rst_drop", drop, 16'd1);
    chk("post_rst_pkt", pkt, 16'd0);
    chk("post_rst_wren", wren, 1'b0);
    rxio_tlast = 1'b1;
    @(posedge log_clk); #1;
    idle_in();
    @(posedge log_clk); #1;
    chk("post_rst_nowr", {wren, pkt}, 17'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
